ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between two requesters: instruction fetch (icache miss path) and load/store.
- Serialises each request into 1/2/4 little-endian byte transfers.
- Load/store has priority, with a starvation guard that protects fetch; fetch is flushable on branch mispredict.
- Sits between the icache/LS unit and the RAM, in place of ad-hoc port muxing.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants allowed while inst_req is pending before fetch is forced.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- inst_req  in  1  fetch request; held with stable address until inst_done or flush
- inst_addr  in  ADDR_W  fetch byte address
- inst_flush  in  1  cancel pending/in-flight fetch
- inst_done  out  1  one-cycle pulse; inst_data valid
- inst_data  out  32  fetched word
- ls_req  in  1  LS request; held stable until ls_done
- ls_rw  in  1  0 = read, 1 = write
- ls_addr  in  ADDR_W  LS byte address
- ls_len  in  3  3'b001 / 3'b010 / 3'b100 bytes
- ls_wdata  in  32  store data, byte 0 = [7:0]
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, unread bytes zero
- io_full  in  1  IO output buffer full (see optional feature)
- ram_rw  out  1  1 = write
- ram_addr  out  ADDR_W  RAM byte address
- ram_dout  out  8  write byte
- ram_din  in  8  read byte; RAM returns the byte one edge after the address is presented
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): every output 0, state IDLE, starve counter 0.
- States: IDLE, INST_RD, LS_RD, LS_WR.
- IDLE arbitration at each edge:
  - Requests are ignored in any cycle where inst_done or ls_done is high (completion cycle). This gives requesters time to drop req.
  - If ls_req is pending and (inst_req is low or starve_cnt < STARVE_LIMIT), grant LS. Increment starve_cnt if inst_req is high, saturating at STARVE_LIMIT.
  - Else if inst_req is pending and inst_flush is low, grant fetch and clear starve_cnt.
- Grant actions:
  - Register the address into ram_addr and set stage = 0.
  - LS_WR: ram_rw = 1 and ram_dout = byte 0 in the first cycle.
  - Reads: ram_rw = 0.
- INST_RD:
  - Edges 1..4 capture ram_din into inst_data bytes 0..3; ram_addr increments each edge.
  - At edge 4, go to IDLE and pulse inst_done.
  - Latency: req sampled at edge 0 → inst_done high after edge 4.
- LS_RD: same as INST_RD over N = ls_len bytes. ls_rdata bytes ≥ N are 0. ls_done pulses after edge N.
- LS_WR:
  - One byte per cycle; ram_addr and ram_dout advance each edge.
  - After edge N: ram_rw = 0, ls_done pulses, state IDLE.
- Illegal ls_len (not 1/2/4): no RAM access; ls_done pulses the cycle after grant; ls_rdata = 0.
- Flush:
  - In INST_RD, inst_flush aborts at the next edge: IDLE, no inst_done, inst_data retained.
  - Flush coinciding with the final capture edge also suppresses inst_done.
  - LS transfers are never aborted.
  - Flush in IDLE blocks the fetch grant for that cycle.
- ram_addr wraps modulo 2^ADDR_W.
- Outputs are held between transfers: inst_data and ls_rdata keep their last values; ram_addr holds.
- Reset mid-transfer: immediate return to IDLE; a partial write is abandoned.

Optional Feature:
- Macro: RAM_ARB_IO_STALL_EN.
- With the macro: an LS write with ls_addr[17:16] == 2'b11 is not granted while io_full = 1. Fetch may be granted meanwhile, and the stall does not increment starve_cnt.
- Without the macro: io_full is ignored.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum
  - LEN_BYTE / LEN_HALF / LEN_WORD encodings
  - IO_REGION = 2'b11 and the IO address-bit positions
  - RAM_READ / RAM_WRITE constants
- Sub-module ram_arb_pick (combinational grant selection from req/flush/io/starve inputs) is the one natural split.

Test Plan:
- Fetch at 0x100, RAM bytes 13,05,00,00 → inst_done after edge 4, inst_data = 0x00000513; ram_addr sequence 0x100..0x103.
- LS write len 2, addr 0x20, data 0xBEEF → cycles with ram_rw = 1: (0x20, EF), (0x21, BE); then ls_done; exactly 2 write cycles.
- Continuous ls_req plus inst_req, STARVE_LIMIT = 4 → four LS grants, then a fetch grant, then LS resumes.
- inst_flush two cycles into INST_RD → IDLE next edge, no inst_done; a following LS read len 1 at 0x7 returns 0x000000xx.
- Both req together in IDLE, LS len 4 read → LS served first, fetch starts the cycle after the ls_done cycle.
- RAM_ARB_IO_STALL_EN, write to 0x30000 with io_full = 1 for 10 cycles → no ram_rw until io_full drops; a fetch issued meanwhile completes.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
// Holds the FSM state enum, ls_len encodings, IO region decode and RAM direction values.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INST_RD = 2'd1,
    LS_RD   = 2'd2,
    LS_WR   = 2'd3
  } arb_state_e;

  localparam logic [2:0] LEN_BYTE = 3'b001;
  localparam logic [2:0] LEN_HALF = 3'b010;
  localparam logic [2:0] LEN_WORD = 3'b100;

  localparam logic [1:0] IO_REGION = 2'b11;
  localparam int         IO_BIT_LO = 16;
  localparam int         IO_BIT_HI = 17;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  function automatic logic len_valid(input logic [2:0] len);
    return (len == LEN_BYTE) || (len == LEN_HALF) || (len == LEN_WORD);
  endfunction

  // Index of the final byte stage for a legal length.
  function automatic logic [1:0] len_last(input logic [2:0] len);
    case (len)
      LEN_HALF: return 2'd1;
      LEN_WORD: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection: load/store first, fetch protected by a starvation limit.
// With RAM_ARB_IO_STALL_EN defined, IO-region writes are held back while io_full_i is high.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             en_i,
  input  logic             inst_req_i,
  input  logic             inst_flush_i,
  input  logic             ls_req_i,
  input  logic             ls_rw_i,
  input  logic [1:0]       ls_io_bits_i,
  input  logic             io_full_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             grant_ls_o,
  output logic             grant_inst_o
);

  logic ls_stall;
  logic ls_eligible;

`ifdef RAM_ARB_IO_STALL_EN
  assign ls_stall = io_full_i && (ls_rw_i == RAM_WRITE) && (ls_io_bits_i == IO_REGION);
`else
  logic unused_io;
  assign unused_io = ^{io_full_i, ls_rw_i, ls_io_bits_i};
  assign ls_stall  = 1'b0;
`endif

  // A stalled IO write is simply not a candidate, so it never bumps the starve count.
  assign ls_eligible = ls_req_i && !ls_stall &&
                       (!inst_req_i || (starve_cnt_i < CNT_W'(STARVE_LIMIT)));

  always_comb begin
    grant_ls_o   = 1'b0;
    grant_inst_o = 1'b0;
    if (en_i) begin
      if (ls_eligible) begin
        grant_ls_o = 1'b1;
      end else if (inst_req_i && !inst_flush_i) begin
        grant_inst_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store, serialising
// 1/2/4-byte little-endian transfers. Optional IO write stall: RAM_ARB_IO_STALL_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_flush,
  output logic              inst_done,
  output logic [31:0]       inst_data,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_len,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic              io_full,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q;
  logic [1:0]        stage_q;
  logic [1:0]        last_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rw_q;
  logic [7:0]        ram_dout_q;
  logic [31:0]       inst_data_q;
  logic [31:0]       ls_rdata_q;
  logic              inst_done_q;
  logic              ls_done_q;
  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;

  logic       arb_en;
  logic       grant_ls;
  logic       grant_inst;
  logic [1:0] stage_nxt;
  logic [4:0] byte_sel;
  logic [4:0] byte_nxt;

  // No arbitration during a completion cycle so the requester can drop its req.
  assign arb_en    = (state_q == IDLE) && !inst_done_q && !ls_done_q;
  assign stage_nxt = stage_q + 2'd1;
  assign byte_sel  = {stage_q, 3'b000};
  assign byte_nxt  = {stage_nxt, 3'b000};

  ram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .en_i        (arb_en),
    .inst_req_i  (inst_req),
    .inst_flush_i(inst_flush),
    .ls_req_i    (ls_req),
    .ls_rw_i     (ls_rw),
    .ls_io_bits_i(ls_addr[IO_BIT_HI:IO_BIT_LO]),
    .io_full_i   (io_full),
    .starve_cnt_i(starve_q),
    .grant_ls_o  (grant_ls),
    .grant_inst_o(grant_inst)
  );

  always_comb begin
    starve_d = starve_q;
    if (grant_inst) begin
      starve_d = '0;
    end else if (grant_ls && inst_req && (starve_q < CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= 2'd0;
      last_q      <= 2'd0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_rw_q    <= RAM_READ;
      ram_dout_q  <= '0;
      inst_data_q <= '0;
      ls_rdata_q  <= '0;
      inst_done_q <= 1'b0;
      ls_done_q   <= 1'b0;
      starve_q    <= '0;
    end else begin
      inst_done_q <= 1'b0;
      ls_done_q   <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE: begin
          if (grant_ls) begin
            ls_rdata_q <= '0;
            if (len_valid(ls_len)) begin
              ram_addr_q <= ls_addr;
              stage_q    <= 2'd0;
              last_q     <= len_last(ls_len);
              wdata_q    <= ls_wdata;
              if (ls_rw == RAM_WRITE) begin
                ram_rw_q   <= RAM_WRITE;
                ram_dout_q <= ls_wdata[7:0];
                state_q    <= LS_WR;
              end else begin
                ram_rw_q <= RAM_READ;
                state_q  <= LS_RD;
              end
            end else begin
              ls_done_q <= 1'b1;
            end
          end else if (grant_inst) begin
            ram_addr_q <= inst_addr;
            stage_q    <= 2'd0;
            last_q     <= 2'd3;
            ram_rw_q   <= RAM_READ;
            state_q    <= INST_RD;
          end
        end
        INST_RD: begin
          // A flush wins even over the final capture, so inst_done is never raised.
          if (inst_flush) begin
            state_q <= IDLE;
          end else begin
            inst_data_q[byte_sel +: 8] <= ram_din;
            if (stage_q == last_q) begin
              state_q     <= IDLE;
              inst_done_q <= 1'b1;
            end else begin
              stage_q    <= stage_nxt;
              ram_addr_q <= ram_addr_q + ADDR_W'(1);
            end
          end
        end
        LS_RD: begin
          ls_rdata_q[byte_sel +: 8] <= ram_din;
          if (stage_q == last_q) begin
            state_q   <= IDLE;
            ls_done_q <= 1'b1;
          end else begin
            stage_q    <= stage_nxt;
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
          end
        end
        LS_WR: begin
          if (stage_q == last_q) begin
            ram_rw_q  <= RAM_READ;
            state_q   <= IDLE;
            ls_done_q <= 1'b1;
          end else begin
            stage_q    <= stage_nxt;
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            ram_dout_q <= wdata_q[byte_nxt +: 8];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_done = inst_done_q;
  assign inst_data = inst_data_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level memory model. Honours RAM_ARB_IO_STALL_EN.
module tb_ram_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int ADDR_W       = 32;
  localparam int TIMEOUT      = 60;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_flush;
  logic              inst_done;
  logic [31:0]       inst_data;
  logic              ls_req;
  logic              ls_rw;
  logic [ADDR_W-1:0] ls_addr;
  logic [2:0]        ls_len;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;
  logic              io_full;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_flush(inst_flush),
    .inst_done (inst_done),
    .inst_data (inst_data),
    .ls_req    (ls_req),
    .ls_rw     (ls_rw),
    .ls_addr   (ls_addr),
    .ls_len    (ls_len),
    .ls_wdata  (ls_wdata),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .io_full   (io_full),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .busy      (busy)
  );

  // RAM model: the byte at the presented address is available to the next edge.
  logic [7:0]  mem    [0:1023];
  logic [7:0]  shadow [0:1023];
  logic        memInit;
  int          wrCount;
  logic [31:0] wrLogAddr [0:15];
  logic [7:0]  wrLogData [0:15];
  int          lsDoneTotal;
  int          instDoneTotal;
  int          instSnapLs;
  int          vectors;
  int          miscompares;

  assign ram_din = mem[ram_addr[9:0]];

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 1024; i++) mem[i] <= shadow[i];
    end else if (ram_rw) begin
      mem[ram_addr[9:0]]       <= ram_dout;
      wrLogAddr[wrCount & 15]  <= ram_addr;
      wrLogData[wrCount & 15]  <= ram_dout;
      wrCount                  <= wrCount + 1;
    end
  end

  always @(negedge clk) begin
    if (ls_done) lsDoneTotal <= lsDoneTotal + 1;
    if (inst_done) begin
      instDoneTotal <= instDoneTotal + 1;
      instSnapLs    <= lsDoneTotal;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int nbytes(input logic [2:0] len);
    case (len)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  // Expected little-endian word of n bytes from the model; unread bytes are zero.
  function automatic logic [31:0] expWord(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] idx;
    w = '0;
    for (int i = 0; i < n; i++) begin
      idx = a + 32'(i);
      w[8*i +: 8] = shadow[idx[9:0]];
    end
    return w;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] idx;
    for (int i = 0; i < 4; i++) begin
      idx = a + 32'(i);
      w[8*i +: 8] = mem[idx[9:0]];
    end
    return w;
  endfunction

  task automatic shadowWrite(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = a + 32'(i);
      shadow[idx[9:0]] = d[8*i +: 8];
    end
  endtask

  // Raises one request, waits (bounded) for its done pulse, then drops it.
  task automatic applyStimulus(input bit isFetch, input logic rw, input logic [31:0] addr,
                               input logic [2:0] len, input logic [31:0] wdata,
                               output int cycles, output logic [31:0] data);
    cycles = 0;
    if (isFetch) begin
      inst_addr = addr;
      inst_req  = 1'b1;
    end else begin
      ls_rw    = rw;
      ls_addr  = addr;
      ls_len   = len;
      ls_wdata = wdata;
      ls_req   = 1'b1;
    end
    do begin
      @(negedge clk);
      cycles++;
    end while (!(isFetch ? inst_done : ls_done) && cycles < TIMEOUT);
    if (isFetch) begin
      data     = inst_data;
      inst_req = 1'b0;
    end else begin
      data   = ls_rdata;
      ls_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          cyc2;
    int          base;
    int          base2;
    int          wrBase;
    int          wrMid;
    logic [31:0] d;
    logic [31:0] d2;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    inst_req    = 1'b0;
    inst_addr   = '0;
    inst_flush  = 1'b0;
    ls_req      = 1'b0;
    ls_rw       = 1'b0;
    ls_addr     = '0;
    ls_len      = 3'b001;
    ls_wdata    = '0;
    io_full     = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = 8'($urandom);
    shadow[10'h100] = 8'h13;
    shadow[10'h101] = 8'h05;
    shadow[10'h102] = 8'h00;
    shadow[10'h103] = 8'h00;
    memInit = 1'b1;
    repeat (3) @(negedge clk);
    memInit = 1'b0;

    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_dones", 32'({inst_done, ls_done, ram_rw}), 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_dout", 32'(ram_dout), 0);
    checkOutput("rst_inst_data", inst_data, 0);
    checkOutput("rst_ls_rdata", ls_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] fetch at 0x100");
    inst_addr = 32'h100;
    inst_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("fetch_ram_addr", ram_addr, 32'h100 + 32'(k));
    end
    @(negedge clk);
    checkOutput("fetch_done", 32'(inst_done), 1);
    checkOutput("fetch_data", inst_data, 32'h0000_0513);
    inst_req = 1'b0;
    @(negedge clk);

    $display("[TB] halfword write 0xBEEF at 0x20");
    wrBase = wrCount;
    applyStimulus(0, 1'b1, 32'h20, 3'b010, 32'h0000_BEEF, cyc, d);
    shadowWrite(32'h20, 2, 32'h0000_BEEF);
    checkOutput("wr_lat", cyc, 3);
    checkOutput("wr_cycles", wrCount - wrBase, 2);
    checkOutput("wr_addr0", wrLogAddr[wrBase & 15], 32'h20);
    checkOutput("wr_data0", 32'(wrLogData[wrBase & 15]), 32'hEF);
    checkOutput("wr_addr1", wrLogAddr[(wrBase + 1) & 15], 32'h21);
    checkOutput("wr_data1", 32'(wrLogData[(wrBase + 1) & 15]), 32'hBE);
    checkOutput("wr_mem", memWord(32'h20), expWord(32'h20, 4));
    @(negedge clk);

    $display("[TB] starvation guard");
    base  = lsDoneTotal;
    base2 = instDoneTotal;
    fork
      begin
        for (int k = 0; k < 6; k++) applyStimulus(0, 1'b0, 32'h280, 3'b001, 0, cyc, d);
      end
      begin
        applyStimulus(1, 1'b0, 32'h1C0, 3'b000, 0, cyc2, d2);
      end
    join
    repeat (2) @(negedge clk);
    checkOutput("starve_ls_before_fetch", instSnapLs - base, STARVE_LIMIT);
    checkOutput("starve_fetch_lat", cyc2, 17);
    checkOutput("starve_fetch_data", d2, expWord(32'h1C0, 4));
    checkOutput("starve_ls_total", lsDoneTotal - base, 6);
    checkOutput("starve_fetch_total", instDoneTotal - base2, 1);

    $display("[TB] flush two cycles into fetch");
    base      = instDoneTotal;
    inst_addr = 32'h140;
    inst_req  = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy_before", 32'(busy), 1);
    @(negedge clk);
    inst_flush = 1'b1;
    inst_req   = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy_after", 32'(busy), 0);
    inst_flush = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("flush_no_done", instDoneTotal - base, 0);
    applyStimulus(0, 1'b0, 32'h7, 3'b001, 0, cyc, d);
    checkOutput("flush_ls_lat", cyc, 2);
    checkOutput("flush_ls_data", d, {24'h0, shadow[7]});
    @(negedge clk);

    $display("[TB] flush on final capture edge");
    base      = instDoneTotal;
    inst_addr = 32'h180;
    inst_req  = 1'b1;
    repeat (4) @(negedge clk);
    inst_flush = 1'b1;
    inst_req   = 1'b0;
    @(negedge clk);
    checkOutput("flush_last_done", 32'({inst_done, busy}), 0);
    inst_flush = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("flush_last_no_done", instDoneTotal - base, 0);

    $display("[TB] flush while idle blocks grant");
    inst_addr  = 32'h60;
    inst_req   = 1'b1;
    inst_flush = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_flush_busy", 32'(busy), 0);
    inst_flush = 1'b0;
    applyStimulus(1, 1'b0, 32'h60, 3'b000, 0, cyc, d);
    checkOutput("idle_flush_lat", cyc, 5);
    checkOutput("idle_flush_data", d, expWord(32'h60, 4));
    @(negedge clk);

    $display("[TB] simultaneous requests");
    fork
      applyStimulus(0, 1'b0, 32'h240, 3'b100, 0, cyc, d);
      applyStimulus(1, 1'b0, 32'h80, 3'b000, 0, cyc2, d2);
    join
    checkOutput("both_ls_lat", cyc, 5);
    checkOutput("both_ls_data", d, expWord(32'h240, 4));
    checkOutput("both_fetch_lat", cyc2, 11);
    checkOutput("both_fetch_data", d2, expWord(32'h80, 4));
    @(negedge clk);

    $display("[TB] fetch across address wrap");
    applyStimulus(1, 1'b0, 32'hFFFF_FFFE, 3'b000, 0, cyc, d);
    checkOutput("wrap_lat", cyc, 5);
    checkOutput("wrap_data", d, expWord(32'hFFFF_FFFE, 4));
    @(negedge clk);

`ifdef RAM_ARB_IO_STALL_EN
    $display("[TB] IO write stalled by io_full");
    wrBase = wrCount;
    fork
      begin
        io_full = 1'b1;
        repeat (10) @(negedge clk);
        wrMid   = wrCount;
        io_full = 1'b0;
      end
      applyStimulus(0, 1'b1, 32'h0003_0000, 3'b001, 32'hA5, cyc, d);
      begin
        repeat (2) @(negedge clk);
        applyStimulus(1, 1'b0, 32'h40, 3'b000, 0, cyc2, d2);
      end
    join
    shadowWrite(32'h0003_0000, 1, 32'hA5);
    checkOutput("io_no_write_while_full", wrMid - wrBase, 0);
    checkOutput("io_fetch_lat", cyc2, 5);
    checkOutput("io_fetch_data", d2, expWord(32'h40, 4));
    checkOutput("io_ls_lat", cyc, 12);
    checkOutput("io_write_cycles", wrCount - wrBase, 1);
`else
    $display("[TB] IO write with io_full ignored");
    wrBase  = wrCount;
    io_full = 1'b1;
    applyStimulus(0, 1'b1, 32'h0003_0000, 3'b001, 32'hA5, cyc, d);
    io_full = 1'b0;
    shadowWrite(32'h0003_0000, 1, 32'hA5);
    checkOutput("io_ls_lat", cyc, 2);
    checkOutput("io_write_cycles", wrCount - wrBase, 1);
`endif
    checkOutput("io_mem", memWord(32'h0), expWord(32'h0, 4));
    @(negedge clk);

    $display("[TB] randomized transactions");
    for (int k = 0; k < 60; k++) begin
      int          kind;
      int          sel;
      int          n;
      logic        rw;
      logic [2:0]  len;
      logic [31:0] a;
      logic [31:0] wd;
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        a = 32'($urandom_range(0, 511));
        applyStimulus(1, 1'b0, a, 3'b000, 0, cyc, d);
        checkOutput("rnd_fetch_lat", cyc, 5);
        checkOutput("rnd_fetch_data", d, expWord(a, 4));
      end else begin
        rw  = 1'($urandom_range(0, 1));
        a   = 32'(512 + $urandom_range(0, 500));
        wd  = $urandom;
        sel = int'($urandom_range(0, 8));
        case (sel)
          0, 1:    len = 3'b001;
          2, 3:    len = 3'b010;
          4, 5:    len = 3'b100;
          6:       len = 3'b000;
          7:       len = 3'b011;
          default: len = 3'($urandom_range(5, 7));
        endcase
        n      = nbytes(len);
        wrBase = wrCount;
        applyStimulus(0, rw, a, len, wd, cyc, d);
        checkOutput("rnd_ls_lat", cyc, (n == 0) ? 1 : n + 1);
        if (rw) begin
          shadowWrite(a, n, wd);
          checkOutput("rnd_wr_cycles", wrCount - wrBase, n);
          checkOutput("rnd_wr_mem", memWord(a), expWord(a, 4));
        end else begin
          checkOutput("rnd_rd_data", d, expWord(a, n));
        end
      end
      @(negedge clk);
    end

    $display("[TB] reset in the middle of a write");
    ls_rw    = 1'b1;
    ls_addr  = 32'h300;
    ls_len   = 3'b100;
    ls_wdata = 32'h1122_3344;
    ls_req   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_state", 32'({busy, ram_rw, ls_done}), 0);
    checkOutput("midrst_ram_addr", ram_addr, 0);
    ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_idle", 32'({busy, ram_rw}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
